divrem_arbiter: RTL and testbench
=================================

Name: divrem_arbiter

Overview:
- Shares one divrem instance between NREQ requesters, e.g. several primogen cores or a primogen core plus a host divide port.
- Each requester hands over one {num, den} job through a valid/ready handshake. The operands are buffered per slot.
- The arbiter issues jobs to the divider in round-robin order and returns rem/error to the owning slot as a one-cycle response pulse.
- A watchdog flags a divider that never reports ready.

Parameters:
- WIDTH_LOG, 4, operand width is WIDTH = 1 << WIDTH_LOG; must match the attached divrem.
- NREQ, 2, number of requester slots, 2..4.
- TIMEOUT, 64, maximum cycles spent in WAIT before the watchdog fires, 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; the block is reset on any rising clk edge where rst == 0.
- req_valid  in  NREQ  per-slot job request.
- req_ready  out  NREQ  per-slot, can accept a job.
- req_num  in  NREQ*WIDTH  slot i dividend at bits [i*WIDTH +: WIDTH].
- req_den  in  NREQ*WIDTH  slot i divisor, same packing.
- resp_valid  out  NREQ  one-cycle pulse, result for slot i.
- resp_rem  out  WIDTH  remainder; valid only when some resp_valid bit is 1.
- resp_error  out  1  divider error or watchdog fire; qualified by resp_valid.
- timeout_seen  out  1  sticky flag, set on any watchdog fire.
- div_go  out  1  to divrem go.
- div_num  out  WIDTH  to divrem num.
- div_den  out  WIDTH  to divrem den.
- div_ready  in  1  from divrem.
- div_error  in  1  from divrem.
- div_rem  in  WIDTH  from divrem.

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready = all 1.
  - resp_valid = 0, resp_rem = 0, resp_error = 0, timeout_seen = 0.
  - div_go = 0, div_num = 0, div_den = 0.
  - pending = 0, last_grant = NREQ-1, state = IDLE.
- The top level must reset divrem in the same cycle.
- Slot buffers:
  - req_ready[i] = !pending[i].
  - A handshake (req_valid[i] && req_ready[i]) latches num/den into slot i and sets pending[i].
  - pending[i] clears on the edge where resp_valid[i] is driven high, so req_ready[i] returns 1 in the cycle after the response pulse.
  - Only one job per slot is ever outstanding.
- State machine:
  - IDLE: if pending != 0, grant the first pending slot searching from last_grant+1 modulo NREQ.
    - Load div_num/div_den from that slot and assert div_go for exactly one cycle; go to SETTLE.
    - Otherwise stay in IDLE.
  - SETTLE: one cycle, so divrem can register its inputs and drop ready. Clear the watchdog counter; go to WAIT.
  - WAIT: div_num/div_den are held stable throughout.
    - If div_error is 1: drive resp_valid[g] = 1, resp_error = 1, resp_rem = 0; go to IDLE.
    - Else if div_ready is 1: drive resp_valid[g] = 1, resp_error = 0, resp_rem = div_rem; go to IDLE.
    - Else if the counter reaches TIMEOUT-1: drive resp_valid[g] = 1, resp_error = 1, resp_rem = 0; set timeout_seen; go to FLUSH.
    - Otherwise increment the counter.
  - FLUSH: wait, with no timeout, for div_ready or div_error, then go to IDLE. No response is issued from FLUSH.
  - On every IDLE entry, last_grant is set to g.
  - Illegal state: drive outputs to X in simulation, then recover to IDLE.
- Latency: the minimum from accepted request to response is 4 cycles plus divrem latency (accept, IDLE grant, SETTLE, WAIT sample). With multiple slots pending, the arbiter returns to IDLE and grants the next slot in the cycle after a response.
- Fairness: with all slots continuously pending, the grant order is strictly 0,1,…,NREQ-1,0,…
- A new request to a slot whose result pulses in the same cycle is not accepted in that cycle.
- Arithmetic: den = 0 is forwarded unchanged; divrem reports the error, which is passed through.
- Watchdog counter: 8 bits, saturating.
- resp_rem is held at its last value while resp_valid = 0.
- Reset mid-operation: the pending job is dropped, with no response pulse, and the block returns to its reset values on the next edge.
- Simulation checks:
  - At most one resp_valid bit high at a time.
  - div_go is never asserted outside IDLE→SETTLE.
  - No X on rst or clk.

Test Plan:
- Single job, slot 0: num = 17, den = 5 -> div_go pulses once with div_num = 17, div_den = 5; resp_valid = 01, resp_rem = 2, resp_error = 0; req_ready[0] low from accept until the cycle after the pulse.
- Simultaneous requests: slot 0 (100, 7) and slot 1 (100, 9) in the same cycle after reset -> slot 0 is served first (last_grant = 1); responses are slot 0 rem = 2, then slot 1 rem = 1; there is exactly one IDLE cycle between them.
- Fairness: both slots re-request every time they are ready for 8 jobs -> grants alternate 0,1,0,1,…; no slot is served twice in a row.
- Divide by zero: slot 1, num = 9, den = 0 -> resp_valid = 10, resp_error = 1, resp_rem = 0; timeout_seen stays 0.
- Watchdog: a stub divider holds div_ready = 0 with TIMEOUT = 8 -> the response pulse comes 8 cycles after SETTLE with resp_error = 1 and timeout_seen = 1; no new div_go until the stub raises ready.
- Reset mid-WAIT: drive rst = 0 for 1 cycle -> pending = 0, req_ready = all 1, no resp_valid pulse, outputs at reset values; a subsequent job 35/6 returns rem = 5.

Source files
------------

// File: rtl/divrem_arbiter.sv
// divrem_arbiter: shares one divrem between NREQ requesters.
// Each slot buffers one {num, den} job. Jobs are issued to the divider in
// round-robin order. Each result comes back to its slot as a one-cycle pulse.
// A watchdog ends a WAIT that never completes and reports it as an error.
// The attached divrem is driven from the same rst, so both clear on one edge.
module divrem_arbiter #(
   parameter int WIDTH_LOG = 4,
   parameter int NREQ      = 2,
   parameter int TIMEOUT   = 64,
   localparam int WIDTH    = 1 << WIDTH_LOG
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_num,
   input  logic [NREQ*WIDTH-1:0] req_den,
   output logic [NREQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]      resp_rem,
   output logic                  resp_error,
   output logic                  timeout_seen,
   output logic                  div_go,
   output logic [WIDTH-1:0]      div_num,
   output logic [WIDTH-1:0]      div_den,
   input  logic                  div_ready,
   input  logic                  div_error,
   input  logic [WIDTH-1:0]      div_rem
);

   localparam int         GW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_FLUSH} state_t;

   state_t            state_q, state_n;
   logic [NREQ-1:0]   pending_q, pending_n;
   logic [NREQ-1:0]   accept;
   logic [GW-1:0]     grant_q, grant_n;
   logic [GW-1:0]     last_grant_q, last_grant_n;
   logic [7:0]        wd_cnt_q, wd_cnt_n;
   logic [WIDTH-1:0]  num_buf [NREQ];
   logic [WIDTH-1:0]  den_buf [NREQ];
   logic [GW-1:0]     pick, cand;
   logic              pick_found;
   logic [NREQ-1:0]   grant_onehot;

   logic              div_go_n;
   logic [WIDTH-1:0]  div_num_n, div_den_n, resp_rem_n;
   logic [NREQ-1:0]   resp_valid_n;
   logic              resp_error_n, timeout_seen_n;

   assign accept       = req_valid & req_ready;
   assign grant_onehot = NREQ'(1) << grant_q;

   // Round-robin search: first pending slot after the last one served
   always_comb begin
      pick       = last_grant_q;
      pick_found = 1'b0;
      cand       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = GW'((int'(last_grant_q) + k) % NREQ);
         if (!pick_found && pending_q[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      state_n        = state_q;
      grant_n        = grant_q;
      last_grant_n   = last_grant_q;
      wd_cnt_n       = wd_cnt_q;
      div_go_n       = 1'b0;
      div_num_n      = div_num;
      div_den_n      = div_den;
      resp_valid_n   = '0;
      resp_rem_n     = resp_rem;
      resp_error_n   = resp_error;
      timeout_seen_n = timeout_seen;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_n   = pick;
               div_num_n = num_buf[pick];
               div_den_n = den_buf[pick];
               div_go_n  = 1'b1;
               state_n   = S_SETTLE;
            end
         end
         S_SETTLE: begin
            wd_cnt_n = '0;
            state_n  = S_WAIT;
         end
         S_WAIT: begin
            if (div_error) begin
               resp_valid_n = grant_onehot;
               resp_error_n = 1'b1;
               resp_rem_n   = '0;
               last_grant_n = grant_q;
               state_n      = S_IDLE;
            end else if (div_ready) begin
               resp_valid_n = grant_onehot;
               resp_error_n = 1'b0;
               resp_rem_n   = div_rem;
               last_grant_n = grant_q;
               state_n      = S_IDLE;
            end else if (wd_cnt_q == WD_LAST) begin
               resp_valid_n   = grant_onehot;
               resp_error_n   = 1'b1;
               resp_rem_n     = '0;
               timeout_seen_n = 1'b1;
               state_n        = S_FLUSH;
            end else if (wd_cnt_q != 8'hFF) begin
               wd_cnt_n = wd_cnt_q + 8'd1;
            end
         end
         S_FLUSH: begin
            if (div_ready || div_error) begin
               last_grant_n = grant_q;
               state_n      = S_IDLE;
            end
         end
         default: begin
            div_go_n       = 1'bx;
            div_num_n      = 'x;
            div_den_n      = 'x;
            resp_valid_n   = 'x;
            resp_rem_n     = 'x;
            resp_error_n   = 1'bx;
            timeout_seen_n = 1'bx;
            state_n        = S_IDLE;
         end
      endcase
      pending_n = (pending_q | accept) & ~resp_valid_n;
   end

   // Control and output registers. req_ready drops on accept and rises only
   // one cycle after the response pulse, so a slot can't re-accept during it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         pending_q    <= '0;
         req_ready    <= '1;
         grant_q      <= '0;
         last_grant_q <= GW'(NREQ - 1);
         wd_cnt_q     <= '0;
         div_go       <= 1'b0;
         div_num      <= '0;
         div_den      <= '0;
         resp_valid   <= '0;
         resp_rem     <= '0;
         resp_error   <= 1'b0;
         timeout_seen <= 1'b0;
      end else begin
         state_q      <= state_n;
         pending_q    <= pending_n;
         req_ready    <= ~(pending_q | accept);
         grant_q      <= grant_n;
         last_grant_q <= last_grant_n;
         wd_cnt_q     <= wd_cnt_n;
         div_go       <= div_go_n;
         div_num      <= div_num_n;
         div_den      <= div_den_n;
         resp_valid   <= resp_valid_n;
         resp_rem     <= resp_rem_n;
         resp_error   <= resp_error_n;
         timeout_seen <= timeout_seen_n;
      end
   end

   // Per-slot operand buffers, loaded on each handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) begin
            num_buf[i] <= '0;
            den_buf[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
               num_buf[i] <= req_num[i*WIDTH +: WIDTH];
               den_buf[i] <= req_den[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Simulation sanity checks on the strobes and control inputs
   a_resp_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(resp_valid));
   a_go_settle   : assert property (@(posedge clk) disable iff (!rst) div_go |-> state_q == S_SETTLE);
   a_no_x        : assert property (@(posedge clk) !$isunknown({rst, clk}));

endmodule

// File: tb/tb_divrem_arbiter.sv
// tb_divrem_arbiter: directed jobs against a behavioural divider, checked by a
// scoreboard that is filled on each handshake and drained by a response monitor.
module tb_divrem_arbiter;

   localparam int W       = 16;
   localparam int DIV_LAT = 3;

   typedef struct {
      logic [W-1:0] num;
      logic [W-1:0] den;
      logic [W-1:0] rem;
      logic         err;
   } job_t;

   typedef struct {
      int           slot;
      logic [W-1:0] rem;
      logic         err;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [1:0]     req_valid, req_ready, resp_valid;
   logic [2*W-1:0] req_num, req_den;
   logic [W-1:0]   resp_rem, div_num, div_den, div_rem;
   logic           resp_error, timeout_seen, div_go, div_ready, div_error;

   job_t jobs [2][$];
   exp_t sb [$];
   exp_t mon_e;
   job_t drv_j;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   go_count = 0;
   int   last_go_cyc = 0;
   int   last_resp_cyc = 0;
   int   prev_resp_cyc = 0;
   int   accept_cyc [2];
   bit   hs_done [2];
   bit   ready_watch [2];
   bit   stub_hang = 1'b0;
   logic [W-1:0] m_num, m_den;
   int   lat_cnt;
   int   g0;

   divrem_arbiter #(.WIDTH_LOG(4), .NREQ(2), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_num(req_num), .req_den(req_den),
      .resp_valid(resp_valid), .resp_rem(resp_rem), .resp_error(resp_error),
      .timeout_seen(timeout_seen),
      .div_go(div_go), .div_num(div_num), .div_den(div_den),
      .div_ready(div_ready), .div_error(div_error), .div_rem(div_rem)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency measurements
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural divider: drops ready on go, answers DIV_LAT cycles later,
   // or never while stub_hang is set
   always @(posedge clk) begin
      if (!rst) begin
         div_ready <= 1'b1;
         div_error <= 1'b0;
         div_rem   <= '0;
         lat_cnt   <= 0;
      end else if (div_go) begin
         div_ready <= 1'b0;
         div_error <= 1'b0;
         m_num     <= div_num;
         m_den     <= div_den;
         lat_cnt   <= DIV_LAT;
      end else if (!div_ready && !stub_hang) begin
         if (lat_cnt <= 1) begin
            div_ready <= 1'b1;
            if (m_den == '0) begin
               div_error <= 1'b1;
               div_rem   <= '0;
            end else begin
               div_rem   <= m_num % m_den;
            end
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   task automatic boundFail(input string name);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: wait budget expired", name);
   endtask

   task automatic applyStimulus(input int slot, input logic [W-1:0] num, input logic [W-1:0] den,
                                input logic [W-1:0] rem, input logic err);
      jobs[slot].push_back('{num: num, den: den, rem: rem, err: err});
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      sb.delete();
      ready_watch[0] = 1'b0;
      ready_watch[1] = 1'b0;
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
   endtask

   task automatic waitGo(input int budget);
      int start = go_count;
      int n = 0;
      while (go_count == start && n < budget) begin
         tick(1);
         n++;
      end
      if (go_count == start) boundFail("wait_go");
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while ((sb.size() != 0 || jobs[0].size() != 0 || jobs[1].size() != 0 || req_valid != 2'b00)
             && n < budget) begin
         tick(1);
         n++;
      end
      if (sb.size() != 0 || jobs[0].size() != 0 || jobs[1].size() != 0) boundFail("wait_idle");
   endtask

   // Driver: presents queued jobs on negedges, records handshakes in the scoreboard
   initial begin
      req_valid = '0;
      req_num   = '0;
      req_den   = '0;
      hs_done[0] = 1'b0;
      hs_done[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            if (hs_done[s]) begin
               req_valid[s] = 1'b0;
               hs_done[s]   = 1'b0;
            end
            if (!req_valid[s] && jobs[s].size() > 0) begin
               req_num[s*W +: W] = jobs[s][0].num;
               req_den[s*W +: W] = jobs[s][0].den;
               req_valid[s]      = 1'b1;
            end
         end
         if (rst) begin
            for (int s = 0; s < 2; s++) begin
               if (req_valid[s] && req_ready[s]) begin
                  drv_j = jobs[s].pop_front();
                  sb.push_back('{slot: s, rem: drv_j.rem, err: drv_j.err});
                  accept_cyc[s] = cyc;
                  hs_done[s]    = 1'b1;
               end
            end
         end
      end
   end

   // Monitor: compares every response pulse against the scoreboard head
   initial begin
      ready_watch[0] = 1'b0;
      ready_watch[1] = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int s = 0; s < 2; s++) begin
               if (ready_watch[s]) begin
                  checkOutput("ready_after_pulse", 32'(req_ready[s]), 32'd1);
                  ready_watch[s] = 1'b0;
               end
            end
            if (div_go) begin
               go_count++;
               last_go_cyc = cyc;
            end
            if (resp_valid != 2'b00) begin
               prev_resp_cyc = last_resp_cyc;
               last_resp_cyc = cyc;
               if (sb.size() == 0) begin
                  checkOutput("resp_unexpected", 32'(resp_valid), 32'd0);
               end else begin
                  mon_e = sb.pop_front();
                  checkOutput("resp_slot", 32'(resp_valid), 32'd1 << mon_e.slot);
                  checkOutput("resp_rem", 32'(resp_rem), 32'(mon_e.rem));
                  checkOutput("resp_error", 32'(resp_error), 32'(mon_e.err));
                  checkOutput("ready_during_pulse", 32'(req_ready & resp_valid), 32'd0);
                  ready_watch[mon_e.slot] = 1'b1;
               end
            end
         end
      end
   end

   // Hard stop in case a wait loop is broken
   initial begin
      #300000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   // Directed test sequence
   initial begin
      rst = 1'b0;
      tick(3);
      rst = 1'b1;
      $display("[TB] reset values");
      checkOutput("rst_req_ready", 32'(req_ready), 32'h3);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rst_resp_rem", 32'(resp_rem), 32'h0);
      checkOutput("rst_resp_error", 32'(resp_error), 32'h0);
      checkOutput("rst_timeout_seen", 32'(timeout_seen), 32'h0);
      checkOutput("rst_div_go", 32'(div_go), 32'h0);
      checkOutput("rst_div_num", 32'(div_num), 32'h0);
      checkOutput("rst_div_den", 32'(div_den), 32'h0);

      $display("[TB] single job 17/5 on slot 0");
      g0 = go_count;
      applyStimulus(0, 16'd17, 16'd5, 16'd2, 1'b0);
      waitGo(20);
      checkOutput("go_num", 32'(div_num), 32'd17);
      checkOutput("go_den", 32'(div_den), 32'd5);
      waitIdle(50);
      checkOutput("go_once", 32'(go_count - g0), 32'd1);
      // accept, IDLE grant, SETTLE, three busy WAIT cycles, WAIT sample
      checkOutput("latency", 32'(last_resp_cyc - accept_cyc[0]), 32'd7);

      $display("[TB] simultaneous requests after reset");
      doReset();
      applyStimulus(0, 16'd100, 16'd7, 16'd2, 1'b0);
      applyStimulus(1, 16'd100, 16'd9, 16'd1, 1'b0);
      waitIdle(80);
      // one IDLE, SETTLE, four WAIT cycles until the second pulse
      checkOutput("resp_gap", 32'(last_resp_cyc - prev_resp_cyc), 32'd6);

      $display("[TB] fairness, 8 back-to-back jobs");
      applyStimulus(0, 16'd50, 16'd7, 16'd1, 1'b0);
      applyStimulus(1, 16'd81, 16'd9, 16'd0, 1'b0);
      applyStimulus(0, 16'd200, 16'd13, 16'd5, 1'b0);
      applyStimulus(1, 16'd99, 16'd10, 16'd9, 1'b0);
      applyStimulus(0, 16'd1000, 16'd33, 16'd10, 1'b0);
      applyStimulus(1, 16'd12345, 16'd100, 16'd45, 1'b0);
      applyStimulus(0, 16'd65535, 16'd256, 16'd255, 1'b0);
      applyStimulus(1, 16'd7, 16'd9, 16'd7, 1'b0);
      waitIdle(200);

      $display("[TB] divide by zero on slot 1");
      applyStimulus(1, 16'd9, 16'd0, 16'd0, 1'b1);
      waitIdle(50);
      checkOutput("dz_timeout_seen", 32'(timeout_seen), 32'd0);

      $display("[TB] watchdog with hung divider");
      stub_hang = 1'b1;
      applyStimulus(0, 16'd40, 16'd6, 16'd0, 1'b1);
      applyStimulus(1, 16'd23, 16'd4, 16'd3, 1'b0);
      waitGo(20);
      begin
         int n = 0;
         while (sb.size() > 1 && n < 40) begin
            tick(1);
            n++;
         end
         if (sb.size() > 1) boundFail("wait_watchdog");
      end
      // go visible in SETTLE, eight WAIT cycles, pulse on the next one
      checkOutput("wd_delay", 32'(last_resp_cyc - last_go_cyc), 32'd9);
      checkOutput("wd_timeout_seen", 32'(timeout_seen), 32'd1);
      g0 = go_count;
      tick(12);
      checkOutput("flush_no_go", 32'(go_count), 32'(g0));
      stub_hang = 1'b0;
      waitIdle(60);
      checkOutput("wd_sticky", 32'(timeout_seen), 32'd1);

      $display("[TB] reset in the middle of WAIT");
      stub_hang = 1'b1;
      applyStimulus(0, 16'd50, 16'd7, 16'd1, 1'b0);
      waitGo(20);
      tick(2);
      doReset();
      checkOutput("mid_req_ready", 32'(req_ready), 32'h3);
      checkOutput("mid_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("mid_resp_rem", 32'(resp_rem), 32'h0);
      checkOutput("mid_timeout_seen", 32'(timeout_seen), 32'h0);
      checkOutput("mid_div_go", 32'(div_go), 32'h0);
      checkOutput("mid_div_num", 32'(div_num), 32'h0);
      tick(10);
      stub_hang = 1'b0;
      applyStimulus(0, 16'd35, 16'd6, 16'd5, 1'b0);
      waitIdle(50);
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
